// File: rtl/uf_pkg.sv
// Shared types for the union-find command sequencer: operation codes,
// controller state encoding and the default node/data width.
package uf_pkg;

    localparam int UF_WIDTH = 32;

    typedef enum logic {
        UF_FIND  = 1'b0,
        UF_UNION = 1'b1
    } uf_op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHK,
        ST_FA_GO,
        ST_FA_WAIT,
        ST_FB_GO,
        ST_FB_WAIT,
        ST_LINK,
        ST_LINK_WAIT,
        ST_RESP
    } uf_ctrl_state_e;

endpackage

// File: rtl/uf_union_ctrl.sv
// Find/union command sequencer: runs the find engine once per operand, links
// distinct roots with parent[max]=min, and arbitrates the single parent-memory port.
module uf_union_ctrl
    import uf_pkg::*;
#(
    parameter int WIDTH     = UF_WIDTH,
    parameter int NUM_NODES = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_root,
    output logic             rsp_merged,
    output logic             rsp_err,
    output logic [CNT_W-1:0] merge_count,
    output logic             eng_start,
    output logic [WIDTH-1:0] eng_node,
    input  logic [WIDTH-1:0] eng_root,
    input  logic             eng_done,
    input  logic             eng_busy,
    input  logic             eng_rd_en,
    input  logic [WIDTH-1:0] eng_addr,
    output logic [WIDTH-1:0] eng_rdata,
    output logic             eng_ready,
    output logic             mem_rd_en,
    output logic             mem_wr_en,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready
);

    localparam logic [WIDTH-1:0] NODES_W = WIDTH'(NUM_NODES);

    uf_ctrl_state_e   state_reg, state_next;
    uf_op_e           op_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] root_a_reg, root_b_reg;
    logic             err_reg, merged_reg;
    logic [CNT_W-1:0] count_reg;

    logic             range_err;
    logic             in_find;
    logic [WIDTH-1:0] link_hi, link_lo;

    assign range_err = (a_reg >= NODES_W) || ((op_reg == UF_UNION) && (b_reg >= NODES_W));
    assign in_find   = (state_reg == ST_FA_GO) || (state_reg == ST_FA_WAIT) ||
                       (state_reg == ST_FB_GO) || (state_reg == ST_FB_WAIT);
    assign link_hi   = (root_a_reg > root_b_reg) ? root_a_reg : root_b_reg;
    assign link_lo   = (root_a_reg > root_b_reg) ? root_b_reg : root_a_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            op_reg     <= UF_FIND;
            a_reg      <= '0;
            b_reg      <= '0;
            root_a_reg <= '0;
            root_b_reg <= '0;
            err_reg    <= 1'b0;
            merged_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && req_valid) begin
                op_reg     <= uf_op_e'(req_op);
                a_reg      <= req_a;
                b_reg      <= req_b;
                err_reg    <= 1'b0;
                merged_reg <= 1'b0;
            end
            if (state_reg == ST_CHK && range_err) begin
                err_reg <= 1'b1;
            end
            if (state_reg == ST_FA_WAIT && eng_done) begin
                root_a_reg <= eng_root;
            end
            if (state_reg == ST_FB_WAIT && eng_done) begin
                root_b_reg <= eng_root;
            end
            // The merge is only counted once the link write has completed.
            if (state_reg == ST_LINK_WAIT && mem_ready) begin
                merged_reg <= 1'b1;
                if (count_reg != {CNT_W{1'b1}}) begin
                    count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (req_valid) state_next = ST_CHK;
            ST_CHK: begin
                if (range_err)      state_next = ST_RESP;
                else if (!eng_busy) state_next = ST_FA_GO;
            end
            ST_FA_GO:     state_next = ST_FA_WAIT;
            ST_FA_WAIT:   if (eng_done) state_next = (op_reg == UF_UNION) ? ST_FB_GO : ST_RESP;
            // The engine leaves its done state on the cycle we spend in FB_GO.
            ST_FB_GO:     state_next = ST_FB_WAIT;
            ST_FB_WAIT:   if (eng_done) state_next = (eng_root == root_a_reg) ? ST_RESP : ST_LINK;
            ST_LINK:      state_next = ST_LINK_WAIT;
            ST_LINK_WAIT: if (mem_ready) state_next = ST_RESP;
            ST_RESP:      if (rsp_ready) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_reg == ST_IDLE);
        rsp_valid  = (state_reg == ST_RESP);
        rsp_err    = 1'b0;
        rsp_merged = 1'b0;
        rsp_root   = '0;
        eng_start  = 1'b0;
        eng_node   = '0;
        eng_ready  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (state_reg == ST_RESP) begin
            rsp_err    = err_reg;
            rsp_merged = merged_reg;
            if (!err_reg) rsp_root = (op_reg == UF_FIND) ? root_a_reg : link_lo;
        end
        if (state_reg == ST_FA_GO) begin
            eng_start = 1'b1;
            eng_node  = a_reg;
        end else if (state_reg == ST_FB_GO) begin
            eng_start = 1'b1;
            eng_node  = b_reg;
        end
        if (in_find) begin
            mem_rd_en = eng_rd_en;
            mem_addr  = eng_addr;
            eng_ready = mem_ready;
        end else if (state_reg == ST_LINK || state_reg == ST_LINK_WAIT) begin
            mem_wr_en = (state_reg == ST_LINK);
            mem_addr  = link_hi;
            mem_wdata = link_lo;
        end
    end

    assign eng_rdata   = mem_rdata;
    assign merge_count = count_reg;

endmodule
